// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, register map
// addresses and cause-register bit positions.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_IDLE   = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CAUSE = 2'd0;
  localparam logic [1:0] ADDR_COUNT = 2'd1;
  localparam logic [1:0] ADDR_SWRST = 2'd2;
  localparam logic [1:0] ADDR_CFG   = 2'd3;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_EXT = 2;
  localparam int CAUSE_SW  = 3;

endpackage

// File: rtl/debounce_sync.sv
// Pushbutton reset conditioning: 2-flop synchronizer followed by a counter that
// accepts the request only after DEBOUNCE_CYCLES consecutive synchronized-low cycles.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ext_n,
  output logic req_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_req;

  // Released condition: synchronizer high, no request pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_sync1 <= i_ext_n;
      r_sync2 <= r_sync1;
      if (r_sync2) begin
        r_cnt <= '0;
        r_req <= 1'b0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CNT_MAX - CW'(1)) r_req <= 1'b1;
      end
    end
  end

  assign req_db = r_req;

endmodule

// File: rtl/reset_sequencer.sv
// Stretched system reset generator with watchdog, pushbutton and software-key
// reset sources, a sticky cause register and a saturating reset-event counter.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int          STRETCH_CYCLES  = 1024,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] SW_KEY          = 16'hA5C3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wdt_resetrequest,
  input  logic        ext_reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        sys_reset_n,
  output logic        reset_active
);

  localparam logic [15:0] STRETCH_LAST = 16'(STRETCH_CYCLES - 1);
  localparam logic [15:0] CFG_VALUE    = 16'(STRETCH_CYCLES);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] r_count;
  logic [3:0]  r_cause;
  logic [15:0] r_rdata;
  logic        r_sys_rst_n;
  logic        r_active;
  logic        r_wdt_d;
  logic        r_db_d;

  logic        w_req_db;
  logic        w_wr;
  logic        w_wdt_edge;
  logic        w_ext_edge;
  logic        w_sw_key;
  logic        w_trig;
  logic        w_entry;
  logic        w_sys_rst_n_nxt;
  logic [3:0]  w_set;
  logic [3:0]  w_clr;
  logic [15:0] w_rdata;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_ext_n (ext_reset_n),
    .req_db  (w_req_db)
  );

  assign w_wr       = chipselect & ~write_n;
  assign w_wdt_edge = wdt_resetrequest & ~r_wdt_d;
  assign w_ext_edge = w_req_db & ~r_db_d;
  assign w_sw_key   = w_wr && (address == ADDR_SWRST) && (writedata == SW_KEY);
  assign w_trig     = w_wdt_edge | w_ext_edge | w_sw_key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ASSERT;
    else          r_state <= w_state_nxt;
  end

  // A trigger always wins: it restarts ASSERT or re-enters it from HOLD/IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ASSERT: if (!w_trig && r_cnt == STRETCH_LAST) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_trig)                                   w_state_nxt = ST_ASSERT;
        else if (!(wdt_resetrequest || w_req_db))     w_state_nxt = ST_IDLE;
      end
      ST_IDLE:   if (w_trig) w_state_nxt = ST_ASSERT;
      default:   w_state_nxt = ST_ASSERT;
    endcase
  end

  always_comb begin
    w_sys_rst_n_nxt = (w_state_nxt == ST_IDLE);
    w_entry         = w_trig && (r_state != ST_ASSERT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_sys_rst_n <= 1'b0;
      r_active    <= 1'b1;
      r_wdt_d     <= 1'b0;
      r_db_d      <= 1'b0;
    end else begin
      r_cnt       <= (r_state == ST_ASSERT && w_state_nxt == ST_ASSERT && !w_trig)
                     ? r_cnt + 16'd1 : 16'd0;
      r_sys_rst_n <= w_sys_rst_n_nxt;
      r_active    <= ~w_sys_rst_n_nxt;
      r_wdt_d     <= wdt_resetrequest;
      r_db_d      <= w_req_db;
    end
  end

  always_comb begin
    w_set            = '0;
    w_set[CAUSE_WDT] = w_wdt_edge;
    w_set[CAUSE_EXT] = w_ext_edge;
    w_set[CAUSE_SW]  = w_sw_key;
    w_clr            = (w_wr && address == ADDR_CAUSE) ? writedata[3:0] : 4'd0;
  end

  // Cause and count survive sys_reset_n; only power-on reset touches them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause <= 4'b0001;
      r_count <= '0;
    end else begin
      r_cause <= (r_cause & ~w_clr) | w_set;
      if (w_wr && address == ADDR_COUNT) r_count <= '0;
      else if (w_entry && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_CAUSE: w_rdata = {12'd0, r_cause};
      ADDR_COUNT: w_rdata = r_count;
      ADDR_SWRST: w_rdata = '0;
      ADDR_CFG:   w_rdata = CFG_VALUE;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rdata <= '0;
    else          r_rdata <= w_rdata;
  end

  assign readdata     = r_rdata;
  assign sys_reset_n  = r_sys_rst_n;
  assign reset_active = r_active;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STRETCH_CYCLES=8, DEBOUNCE_CYCLES=4.
// A reset sequence spans 8 ASSERT cycles plus at least one HOLD cycle.
module tb_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wdt_resetrequest;
  logic        ext_reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        sys_reset_n;
  logic        reset_active;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .STRETCH_CYCLES (8),
    .DEBOUNCE_CYCLES(4),
    .SW_KEY         (16'hA5C3)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wdt_resetrequest(wdt_resetrequest),
    .ext_reset_n     (ext_reset_n),
    .address         (address),
    .chipselect      (chipselect),
    .write_n         (write_n),
    .writedata       (writedata),
    .readdata        (readdata),
    .sys_reset_n     (sys_reset_n),
    .reset_active    (reset_active)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [15:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  // Returns the number of clocks until sys_reset_n reaches v (max on timeout).
  task automatic wait_sys(input logic v, input int max, output int n);
    n = 0;
    while (sys_reset_n !== v && n < max) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset;
    logic [15:0] rd;
    int n;
    reset_n = 1'b0;
    tick(2);
    checks++;
    if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL por_sys_reset_n: got %b expected 0", sys_reset_n); end
    checks++;
    if (reset_active !== 1'b1) begin errors++; $display("FAIL por_reset_active: got %b expected 1", reset_active); end
    checks++;
    if (readdata !== 16'h0000) begin errors++; $display("FAIL por_readdata: got %h expected 0000", readdata); end
    reset_n = 1'b1;
    wait_sys(1'b1, 50, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL por_release_clocks: got %0d expected 9", n); end
    checks++;
    if (reset_active !== 1'b0) begin errors++; $display("FAIL idle_reset_active: got %b expected 0", reset_active); end
    do_read(2'd0, rd);
    checks++;
    if (rd !== 16'h0001) begin errors++; $display("FAIL por_cause: got %h expected 0001", rd); end
    do_read(2'd1, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL por_count: got %h expected 0000", rd); end
    do_read(2'd3, rd);
    checks++;
    if (rd !== 16'h0008) begin errors++; $display("FAIL cfg_read: got %h expected 0008", rd); end
  endtask

  task automatic test_watchdog;
    logic [15:0] rd;
    wdt_resetrequest = 1'b1;
    tick(1);
    checks++;
    if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL wdt_enter: got %b expected 0", sys_reset_n); end
    tick(19);
    checks++;
    if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL wdt_hold: got %b expected 0", sys_reset_n); end
    wdt_resetrequest = 1'b0;
    tick(1);
    checks++;
    if (sys_reset_n !== 1'b1) begin errors++; $display("FAIL wdt_release: got %b expected 1", sys_reset_n); end
    do_read(2'd0, rd);
    checks++;
    if (rd !== 16'h0003) begin errors++; $display("FAIL wdt_cause: got %h expected 0003", rd); end
    do_read(2'd1, rd);
    checks++;
    if (rd !== 16'h0001) begin errors++; $display("FAIL wdt_count: got %h expected 0001", rd); end
  endtask

  task automatic test_external;
    logic [15:0] rd;
    int n;
    ext_reset_n = 1'b0;
    tick(3);
    ext_reset_n = 1'b1;
    tick(10);
    checks++;
    if (sys_reset_n !== 1'b1) begin errors++; $display("FAIL ext_short_pulse: got %b expected 1", sys_reset_n); end
    do_read(2'd0, rd);
    checks++;
    if (rd !== 16'h0003) begin errors++; $display("FAIL ext_short_cause: got %h expected 0003", rd); end
    ext_reset_n = 1'b0;
    tick(6);
    ext_reset_n = 1'b1;
    wait_sys(1'b0, 20, n);
    checks++;
    if (n >= 20) begin errors++; $display("FAIL ext_long_enter: got timeout after %0d clocks expected sys_reset_n=0", n); end
    wait_sys(1'b1, 40, n);
    checks++;
    if (n >= 40) begin errors++; $display("FAIL ext_long_release: got timeout after %0d clocks expected sys_reset_n=1", n); end
    do_read(2'd0, rd);
    checks++;
    if (rd !== 16'h0007) begin errors++; $display("FAIL ext_cause: got %h expected 0007", rd); end
    do_read(2'd1, rd);
    checks++;
    if (rd !== 16'h0002) begin errors++; $display("FAIL ext_count: got %h expected 0002", rd); end
  endtask

  task automatic test_software;
    logic [15:0] rd;
    int n;
    do_write(2'd0, 16'h0006);
    do_read(2'd0, rd);
    checks++;
    if (rd !== 16'h0001) begin errors++; $display("FAIL sw_clear_cause: got %h expected 0001", rd); end
    do_write(2'd2, 16'h1234);
    tick(3);
    checks++;
    if (sys_reset_n !== 1'b1) begin errors++; $display("FAIL sw_wrong_key: got %b expected 1", sys_reset_n); end
    do_write(2'd2, 16'hA5C3);
    checks++;
    if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL sw_key_enter: got %b expected 0", sys_reset_n); end
    wait_sys(1'b1, 40, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL sw_sequence_clocks: got %0d expected 9", n); end
    do_read(2'd0, rd);
    checks++;
    if (rd !== 16'h0009) begin errors++; $display("FAIL sw_cause: got %h expected 0009", rd); end
    do_read(2'd1, rd);
    checks++;
    if (rd !== 16'h0003) begin errors++; $display("FAIL sw_count: got %h expected 0003", rd); end
    do_read(2'd2, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL swrst_read: got %h expected 0000", rd); end
  endtask

  task automatic test_restart;
    int n;
    do_write(2'd0, 16'h0008);
    wdt_resetrequest = 1'b1;
    tick(1);
    wdt_resetrequest = 1'b0;
    tick(4);
    // Fifth ASSERT cycle: new watchdog edge restarts the stretch.
    wdt_resetrequest = 1'b1;
    tick(1);
    wdt_resetrequest = 1'b0;
    wait_sys(1'b1, 60, n);
    // 5 + 8 ASSERT cycles and one HOLD: release 9 clocks after the restart edge.
    checks++;
    if (n !== 9) begin errors++; $display("FAIL restart_clocks: got %0d expected 9", n); end
  endtask

  task automatic test_set_clear_collision;
    logic [15:0] rd;
    int n;
    wdt_resetrequest = 1'b1;
    address = 2'd0; writedata = 16'h000F; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    wdt_resetrequest = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    checks++;
    if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL collide_enter: got %b expected 0", sys_reset_n); end
    wait_sys(1'b1, 40, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL collide_clocks: got %0d expected 9", n); end
    do_read(2'd0, rd);
    checks++;
    if (rd !== 16'h0002) begin errors++; $display("FAIL collide_cause: got %h expected 0002", rd); end
    do_read(2'd1, rd);
    checks++;
    if (rd !== 16'h0005) begin errors++; $display("FAIL entry_count: got %h expected 0005", rd); end
    do_write(2'd1, 16'h0055);
    do_read(2'd1, rd);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL count_clear: got %h expected 0000", rd); end
  endtask

  initial begin
    reset_n          = 1'b0;
    wdt_resetrequest = 1'b0;
    ext_reset_n      = 1'b1;
    address          = 2'd0;
    chipselect       = 1'b0;
    write_n          = 1'b1;
    writedata        = 16'h0000;
    test_reset();
    test_watchdog();
    test_external();
    test_software();
    test_restart();
    test_set_clear_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
